// File: rtl/sys_defs.sv
// Shared widths and reservation-station entry types.
// Holds RS_SRC/RS_ENTRY plus the operand wakeup helper.
package sys_defs;

  localparam int XLEN  = 32;
  localparam int TAG_W = 3;
  localparam int OP_W  = 8;

  typedef struct packed {
    logic            rdy;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  val;
  } RS_SRC;

  typedef struct packed {
    logic            busy;
    logic [OP_W-1:0]  op;
    logic [TAG_W-1:0] dest_tag;
    RS_SRC           src1;
    RS_SRC           src2;
  } RS_ENTRY;

  // A pending operand captures the broadcast value on a tag match.
  function automatic RS_SRC src_wake(
    input RS_SRC            s,
    input logic             v,
    input logic [TAG_W-1:0] t,
    input logic [XLEN-1:0]  d
  );
    RS_SRC r;
    r = s;
    if (!s.rdy && v && (s.tag == t)) begin
      r.rdy = 1'b1;
      r.val = d;
    end
    return r;
  endfunction

endpackage

// File: rtl/cdb_rs_if.sv
// Dispatch, CDB snoop and issue handshake bundle.
// master: dispatch/CDB/FU side; slave: reservation station.
interface cdb_rs_if #(
  parameter int NUM_ENTRIES = 4,
  parameter int TAG_W       = sys_defs::TAG_W,
  parameter int OP_W        = sys_defs::OP_W
);
  localparam int XLEN = sys_defs::XLEN;
  localparam int CW   = $clog2(NUM_ENTRIES + 1);

  logic             dispatch_valid;
  logic             dispatch_ready;
  logic [OP_W-1:0]  dispatch_op;
  logic [TAG_W-1:0] dispatch_dest_tag;
  logic             dispatch_src1_rdy;
  logic [TAG_W-1:0] dispatch_src1_tag;
  logic [XLEN-1:0]  dispatch_src1_val;
  logic             dispatch_src2_rdy;
  logic [TAG_W-1:0] dispatch_src2_tag;
  logic [XLEN-1:0]  dispatch_src2_val;
  logic             cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  logic [XLEN-1:0]  cdb_value;
  logic             issue_valid;
  logic             issue_ready;
  logic [OP_W-1:0]  issue_op;
  logic [TAG_W-1:0] issue_dest_tag;
  logic [XLEN-1:0]  issue_src1;
  logic [XLEN-1:0]  issue_src2;
  logic [CW-1:0]    occupancy;

  modport master (
    output dispatch_valid, dispatch_op, dispatch_dest_tag,
    output dispatch_src1_rdy, dispatch_src1_tag, dispatch_src1_val,
    output dispatch_src2_rdy, dispatch_src2_tag, dispatch_src2_val,
    output cdb_valid, cdb_tag, cdb_value, issue_ready,
    input  dispatch_ready, issue_valid, issue_op, issue_dest_tag,
    input  issue_src1, issue_src2, occupancy
  );

  modport slave (
    input  dispatch_valid, dispatch_op, dispatch_dest_tag,
    input  dispatch_src1_rdy, dispatch_src1_tag, dispatch_src1_val,
    input  dispatch_src2_rdy, dispatch_src2_tag, dispatch_src2_val,
    input  cdb_valid, cdb_tag, cdb_value, issue_ready,
    output dispatch_ready, issue_valid, issue_op, issue_dest_tag,
    output issue_src1, issue_src2, occupancy
  );

endinterface

// File: rtl/rs_psel.sv
// Lowest-index priority selector.
// i_req: request vector; o_gnt: one-hot grant; o_valid: any request.
module rs_psel #(
  parameter int N = 4
) (
  input  logic [N-1:0] i_req,
  output logic [N-1:0] o_gnt,
  output logic         o_valid
);

  // Two's-complement trick isolates the lowest set bit.
  assign o_gnt   = i_req & (~i_req + N'(1));
  assign o_valid = |i_req;

endmodule

// File: rtl/cdb_rs.sv
// CDB-snooping reservation station feeding one functional unit.
// Ports: clock, reset_n, flush, bus (cdb_rs_if.slave).
module cdb_rs #(
  parameter int NUM_ENTRIES = 4,
  parameter int TAG_W       = sys_defs::TAG_W,
  parameter int OP_W        = sys_defs::OP_W
) (
  input logic        clock,
  input logic        reset_n,
  input logic        flush,
  cdb_rs_if.slave    bus
);
  import sys_defs::*;

  localparam int CW = $clog2(NUM_ENTRIES + 1);

  RS_ENTRY r_ent [NUM_ENTRIES];
  logic [CW-1:0] r_occ;

  logic [NUM_ENTRIES-1:0] w_free;
  logic [NUM_ENTRIES-1:0] w_rdy;
  logic [NUM_ENTRIES-1:0] w_free_gnt;
  logic [NUM_ENTRIES-1:0] w_iss_gnt;
  logic w_free_any;
  logic w_iss_any;
  logic w_dfire;
  logic w_ifire;
  RS_SRC   w_s1;
  RS_SRC   w_s2;
  RS_ENTRY w_new;

  always_comb begin
    w_free = '0;
    w_rdy  = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      w_free[i] = ~r_ent[i].busy;
      w_rdy[i]  = r_ent[i].busy & r_ent[i].src1.rdy
                & r_ent[i].src2.rdy;
    end
  end

  rs_psel #(.N(NUM_ENTRIES)) u_free_sel (
    .i_req  (w_free),
    .o_gnt  (w_free_gnt),
    .o_valid(w_free_any)
  );

  rs_psel #(.N(NUM_ENTRIES)) u_iss_sel (
    .i_req  (w_rdy),
    .o_gnt  (w_iss_gnt),
    .o_valid(w_iss_any)
  );

  assign bus.dispatch_ready = w_free_any;
  assign bus.issue_valid    = w_iss_any;
  assign bus.occupancy      = r_occ;

  // Flush drops the dispatch; issue still completes on the FU side.
  assign w_dfire = bus.dispatch_valid & w_free_any & ~flush;
  assign w_ifire = w_iss_any & bus.issue_ready;

  always_comb begin
    w_s1.rdy = bus.dispatch_src1_rdy;
    w_s1.tag = bus.dispatch_src1_tag;
    w_s1.val = bus.dispatch_src1_val;
    w_s2.rdy = bus.dispatch_src2_rdy;
    w_s2.tag = bus.dispatch_src2_tag;
    w_s2.val = bus.dispatch_src2_val;
    // Same-cycle broadcast is bypassed into the new entry.
    w_new.busy     = 1'b1;
    w_new.op       = bus.dispatch_op;
    w_new.dest_tag = bus.dispatch_dest_tag;
    w_new.src1     = src_wake(w_s1, bus.cdb_valid,
                              bus.cdb_tag, bus.cdb_value);
    w_new.src2     = src_wake(w_s2, bus.cdb_valid,
                              bus.cdb_tag, bus.cdb_value);
  end

  always_comb begin
    bus.issue_op       = '0;
    bus.issue_dest_tag = '0;
    bus.issue_src1     = '0;
    bus.issue_src2     = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (w_iss_gnt[i]) begin
        bus.issue_op       = r_ent[i].op;
        bus.issue_dest_tag = r_ent[i].dest_tag;
        bus.issue_src1     = r_ent[i].src1.val;
        bus.issue_src2     = r_ent[i].src2.val;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_ENTRIES; i++)
        r_ent[i] <= '0;
      r_occ <= '0;
    end else if (flush) begin
      for (int i = 0; i < NUM_ENTRIES; i++)
        r_ent[i].busy <= 1'b0;
      r_occ <= '0;
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        if (r_ent[i].busy) begin
          r_ent[i].src1 <= src_wake(r_ent[i].src1,
                             bus.cdb_valid, bus.cdb_tag,
                             bus.cdb_value);
          r_ent[i].src2 <= src_wake(r_ent[i].src2,
                             bus.cdb_valid, bus.cdb_tag,
                             bus.cdb_value);
          if (bus.issue_ready && w_iss_gnt[i])
            r_ent[i].busy <= 1'b0;
        end else if (w_dfire && w_free_gnt[i]) begin
          r_ent[i] <= w_new;
        end
      end
      r_occ <= r_occ + CW'(w_dfire) - CW'(w_ifire);
    end
  end

endmodule

// File: doc/cdb_rs.md
Name: cdb_rs

Overview:
- Consumer end of the common data bus: a small reservation station that snoops the CDB broadcast (valid, 3-bit tag, XLEN value).
- Accepts dispatched instructions whose source operands are either values or pending tags.
- Captures operand values when a matching tag is broadcast.
- Issues fully-ready entries to one functional unit over a valid/ready handshake.
- Sits between dispatch and the functional units; one instance per FU class.

Parameters:
- NUM_ENTRIES, 4, number of station entries (≥2).
- TAG_W, 3, width of CDB/destination tags.
- OP_W, 8, width of the opaque opcode/control payload carried to the FU.
- XLEN is taken from sys_defs (32); it is not a parameter.

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous squash of all entries
- dispatch_valid  in  1  dispatch offers an instruction
- dispatch_ready  out  1  at least one entry free (registered state only)
- dispatch_op  in  OP_W  opcode/control payload
- dispatch_dest_tag  in  TAG_W  tag the result will be broadcast under
- dispatch_src1_rdy  in  1  src1 value valid
- dispatch_src1_tag  in  TAG_W  producer tag when not ready
- dispatch_src1_val  in  XLEN  src1 value when ready
- dispatch_src2_rdy, dispatch_src2_tag, dispatch_src2_val  in  1/TAG_W/XLEN  same as src1
- cdb_valid  in  1  broadcast valid
- cdb_tag  in  TAG_W  broadcast tag
- cdb_value  in  XLEN  broadcast value
- issue_valid  out  1  a fully-ready entry is presented
- issue_ready  in  1  FU accepts this cycle
- issue_op  out  OP_W  payload of the selected entry
- issue_dest_tag  out  TAG_W  destination tag of the selected entry
- issue_src1  out  XLEN  src1 operand of the selected entry
- issue_src2  out  XLEN  src2 operand of the selected entry
- occupancy  out  $clog2(NUM_ENTRIES+1)  count of busy entries

Behaviour:
- Entry state: busy, op, dest_tag, and per source {rdy, tag, val}.
- Reset (reset_n=0, asynchronous): all entries not busy, all fields zero.
  - Outputs during and after reset: dispatch_ready=1, issue_valid=0, occupancy=0, all issue_* data zero.
- Dispatch:
  - Fires when dispatch_valid && dispatch_ready.
  - Writes the lowest-index free entry at the clock edge.
  - dispatch_valid while dispatch_ready=0 is ignored; nothing is written and no error is raised.
- Dispatch/CDB bypass: if a dispatched source has rdy=0 and cdb_valid && cdb_tag==src_tag in the same cycle, that source is written with rdy=1 and val=cdb_value.
- Wakeup: on cdb_valid, every busy entry source with rdy=0 and a matching tag captures cdb_value and sets rdy=1 at the edge.
  - Several sources or entries may wake in the same cycle.
  - Sources already rdy=1 ignore the CDB.
- Issue selection:
  - issue_valid is combinational from registered state: some busy entry has both sources rdy=1.
  - The selected entry is the lowest index among those entries.
  - issue_* show the selected entry; they are all zero when issue_valid=0.
- Issue latency: a CDB broadcast at cycle N makes the entry issuable at N+1, never at N.
  - A dispatch at cycle N with both sources ready (including via bypass) is issuable at N+1.
- Issue handshake: when issue_valid && issue_ready, the selected entry's busy is cleared at the edge. With issue_ready=0, issue_* hold stable (selection is unchanged unless a lower-index entry becomes ready).
- Simultaneous events:
  - Dispatch and issue in the same cycle target different entries.
  - An entry freed by issue is not reusable until the next cycle, because dispatch_ready uses pre-edge state.
  - A full station with issue firing still has dispatch_ready=0.
- Flush:
  - Clears every busy bit at the edge.
  - Overrides a same-cycle dispatch, which is dropped, and a same-cycle wakeup.
  - An issue handshake in the flush cycle still completes at the FU side; the entry is cleared anyway.
- Occupancy: registered popcount of busy; it updates at the same edge as dispatch, issue and flush.
- No state machine beyond per-entry busy/rdy.

Decomposition:
- Shared package (sys_defs), holding:
  - RS_ENTRY struct: busy, op, dest_tag, src1/src2 {rdy, tag, val}
  - RS_SRC struct
  - TAG_W, which must equal the CDB tag width used by the CDB arbiter
- Sub-module rs_psel: parameterised lowest-index priority selector (one-hot grant + valid). Instantiated twice: free-entry select and ready-entry select.

Test Plan:
- Reset then dispatch op=0x11, dest=5, src1 rdy val=7, src2 rdy val=9 → next cycle issue_valid=1, issue_src1=7, issue_src2=9, issue_dest_tag=5; with issue_ready=1, occupancy returns 0.
- Dispatch with src1 pending tag=3; CDB tag=3 value=0xDEAD two cycles later → issue_valid rises exactly one cycle after the broadcast, issue_src1=0xDEAD; a CDB with tag=2 earlier has no effect.
- Dispatch with src2 pending tag=6 in the same cycle as CDB tag=6 value=0x42 → bypass captured; issuable the next cycle with issue_src2=0x42.
- Fill all 4 entries with pending tags → dispatch_ready=0, occupancy=4; broadcast the tag of entry 2 → entry 2 issues first; with issue and dispatch asserted together while full, the dispatch is refused that cycle and accepted the next.
- Two entries waiting on the same tag=1; CDB tag=1 → both wake in one cycle; entry 0 issues before entry 1 under issue_ready=1 on consecutive cycles.
- Assert flush with 3 busy entries and a concurrent dispatch → next cycle occupancy=0, issue_valid=0, dispatch_ready=1. Assert reset_n low mid-wakeup → all outputs zero/idle immediately, without waiting for a clock edge.
